// File: rtl/mc_control_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, ALU codes,
// FSM states, decode classes and IR field positions.
package mc_pkg;

  // IR field positions
  localparam int unsigned IR_OP_LSB  = 28;
  localparam int unsigned IR_RD_LSB  = 24;
  localparam int unsigned IR_RS_LSB  = 20;
  localparam int unsigned IR_RT_LSB  = 16;
  localparam int unsigned IR_IMM_LSB = 0;
  localparam int unsigned IR_IMM_W   = 16;

  // Opcodes
  localparam logic [3:0] OP_MOV  = 4'h0;
  localparam logic [3:0] OP_NOT  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LW   = 4'h9;
  localparam logic [3:0] OP_SW   = 4'hA;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  // ALU operation codes, shared with the ALU
  localparam logic [2:0] ALU_MOV = 3'b000;
  localparam logic [2:0] ALU_NOT = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_ERR    = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE   = 3'd0,
    CLS_ADDI    = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_HALT    = 3'd5,
    CLS_ILLEGAL = 3'd6
  } op_class_t;

  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mc_control_if.sv
// Memory request bus between the control unit (master) and memory (slave).
interface mc_control_if;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;

  modport master (
    input  mem_rdata, mem_ack,
    output mem_req, mem_we, mem_addr_sel
  );

  modport slave (
    output mem_rdata, mem_ack,
    input  mem_req, mem_we, mem_addr_sel
  );
endinterface

// File: rtl/mc_control_decode.sv
// Combinational opcode decoder: instruction class, ALU code and flags.
module mc_decode
  import mc_pkg::*;
(
  input  logic [3:0] opcode,
  output op_class_t  op_class,
  output logic [2:0] alu_op,
  output logic       uses_imm,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_halt,
  output logic       is_illegal
);

  // Opcode to class/control mapping; anything unlisted is illegal
  always_comb begin
    op_class   = CLS_ILLEGAL;
    alu_op     = ALU_MOV;
    uses_imm   = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_branch  = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_MOV, OP_NOT, OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLT: begin
        op_class = CLS_RTYPE;
        alu_op   = opcode[2:0];
      end
      OP_ADDI: begin
        op_class = CLS_ADDI;
        alu_op   = ALU_ADD;
        uses_imm = 1'b1;
      end
      OP_LW: begin
        op_class = CLS_LOAD;
        alu_op   = ALU_ADD;
        uses_imm = 1'b1;
        is_load  = 1'b1;
      end
      OP_SW: begin
        op_class = CLS_STORE;
        alu_op   = ALU_ADD;
        uses_imm = 1'b1;
        is_store = 1'b1;
      end
      OP_BEQ: begin
        op_class  = CLS_BRANCH;
        alu_op    = ALU_SUB;
        is_branch = 1'b1;
      end
      OP_HALT: begin
        op_class = CLS_HALT;
        is_halt  = 1'b1;
      end
      default: begin
        op_class   = CLS_ILLEGAL;
        is_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle control unit with instruction register. Sequences
// FETCH/DECODE/EXEC/MEM/WB and drives datapath selects and enables.
module mc_control
  import mc_pkg::*;
#(
  parameter logic [2:0] RESET_STATE_DBG = 3'd0
)
(
  input  logic         clk,
  input  logic         rst_n,
  mc_control_if.master bus,
  input  logic         alu_zero,
  output logic         pc_we,
  output logic         pc_src,
  output logic         reg_we,
  output logic         reg_wsel,
  output logic [2:0]   alu_op,
  output logic         alu_src_b,
  output logic [3:0]   rd,
  output logic [3:0]   rs,
  output logic [3:0]   rt,
  output logic [31:0]  imm_ext,
  output logic         halted,
  output logic         illegal,
  output logic [2:0]   state_dbg
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] ir;

  logic        mem_req_q;
  logic        mem_we_q;
  logic        mem_addr_sel_q;
  logic        pc_src_q;
  logic        reg_we_q;
  logic        reg_wsel_q;
  logic [2:0]  alu_op_q;
  logic        alu_src_b_q;
  logic        halted_q;
  logic        illegal_q;

  op_class_t   op_class;
  logic [2:0]  dec_alu_op;
  logic        dec_uses_imm;
  logic        dec_is_load;
  logic        dec_is_store;
  logic        dec_is_branch;
  logic        dec_is_halt;
  logic        dec_is_illegal;

  logic        fetch_done;
  logic        mem_done;
  logic        alu_phase_nxt;

  mc_decode u_decode (
    .opcode     (ir[IR_OP_LSB +: 4]),
    .op_class   (op_class),
    .alu_op     (dec_alu_op),
    .uses_imm   (dec_uses_imm),
    .is_load    (dec_is_load),
    .is_store   (dec_is_store),
    .is_branch  (dec_is_branch),
    .is_halt    (dec_is_halt),
    .is_illegal (dec_is_illegal)
  );

  assign fetch_done = (state == ST_FETCH) && bus.mem_ack;
  assign mem_done   = (state == ST_MEM) && bus.mem_ack;

  // Next-state selection; mem_ack only matters in FETCH and MEM
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   state_nxt = ST_FETCH;
      ST_FETCH:  if (fetch_done) state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (dec_is_halt)         state_nxt = ST_HALT;
        else if (dec_is_illegal) state_nxt = ST_ERR;
        else                     state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        case (op_class)
          CLS_LOAD, CLS_STORE: state_nxt = ST_MEM;
          CLS_BRANCH:          state_nxt = ST_FETCH;
          default:             state_nxt = ST_WB;
        endcase
      end
      ST_MEM:    if (mem_done) state_nxt = (op_class == CLS_LOAD) ? ST_WB : ST_FETCH;
      ST_WB:     state_nxt = ST_FETCH;
      ST_HALT:   state_nxt = ST_HALT;
      ST_ERR:    state_nxt = ST_ERR;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign alu_phase_nxt = (state_nxt == ST_EXEC) || (state_nxt == ST_MEM) ||
                         (state_nxt == ST_WB);

  // State, IR and output registers. Outputs are registered from the next
  // state so they stay pure Moore decodes of the state being entered; the
  // IR is already stable whenever the entered state depends on it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      ir             <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_sel_q <= 1'b0;
      pc_src_q       <= 1'b0;
      reg_we_q       <= 1'b0;
      reg_wsel_q     <= 1'b0;
      alu_op_q       <= '0;
      alu_src_b_q    <= 1'b0;
      halted_q       <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      state          <= state_nxt;
      if (fetch_done) ir <= bus.mem_rdata;
      mem_req_q      <= (state_nxt == ST_FETCH) || (state_nxt == ST_MEM);
      mem_addr_sel_q <= (state_nxt == ST_MEM);
      mem_we_q       <= (state_nxt == ST_MEM) && dec_is_store;
      pc_src_q       <= (state_nxt == ST_EXEC) && dec_is_branch;
      alu_src_b_q    <= (state_nxt == ST_EXEC) && dec_uses_imm;
      alu_op_q       <= alu_phase_nxt ? dec_alu_op : ALU_MOV;
      reg_we_q       <= (state_nxt == ST_WB);
      reg_wsel_q     <= (state_nxt == ST_WB) && dec_is_load;
      halted_q       <= (state_nxt == ST_HALT);
      illegal_q      <= (state_nxt == ST_ERR);
    end
  end

  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr_sel = mem_addr_sel_q;

  // PC write is the only output qualified by live inputs
  assign pc_we = fetch_done ||
                 ((state == ST_EXEC) && dec_is_branch && alu_zero);

  assign pc_src    = pc_src_q;
  assign reg_we    = reg_we_q;
  assign reg_wsel  = reg_wsel_q;
  assign alu_op    = alu_op_q;
  assign alu_src_b = alu_src_b_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;

  assign rd      = ir[IR_RD_LSB +: 4];
  assign rs      = ir[IR_RS_LSB +: 4];
  assign rt      = ir[IR_RT_LSB +: 4];
  assign imm_ext = sign_ext16(ir[IR_IMM_LSB +: IR_IMM_W]);

  assign state_dbg = (state == ST_IDLE) ? RESET_STATE_DBG : state;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: instruction-level reference model
// expands each instruction into its expected per-cycle outputs.
module tb_mc_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_zero = 1'b0;
  logic        pc_we, pc_src, reg_we, reg_wsel, alu_src_b, halted, illegal;
  logic [2:0]  alu_op;
  logic [3:0]  rd, rs, rt;
  logic [31:0] imm_ext;
  logic [2:0]  state_dbg;

  mc_control_if m();

  mc_control #(.RESET_STATE_DBG(3'd0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (m),
    .alu_zero  (alu_zero),
    .pc_we     (pc_we),
    .pc_src    (pc_src),
    .reg_we    (reg_we),
    .reg_wsel  (reg_wsel),
    .alu_op    (alu_op),
    .alu_src_b (alu_src_b),
    .rd        (rd),
    .rs        (rs),
    .rt        (rt),
    .imm_ext   (imm_ext),
    .halted    (halted),
    .illegal   (illegal),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mem_req, mem_we, mem_addr_sel, pc_we, pc_src, reg_we, reg_wsel;
    logic [2:0]  alu_op;
    logic        alu_src_b, halted, illegal;
    logic [3:0]  rd, rs, rt;
    logic [31:0] imm;
  } obs_t;

  typedef struct {
    int unsigned wait_n;
    logic [31:0] data;
    logic        is_fetch;
    logic        zero;
  } mem_tgt_t;

  obs_t        exp_q[$];
  mem_tgt_t    tgt_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] ir_m;
  int unsigned wcnt = 0;
  obs_t        mon_e;
  logic [3:0]  legal_ops [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                  4'h8, 4'h9, 4'hA, 4'hB};
  logic [3:0]  bad_ops [4] = '{4'h7, 4'hC, 4'hD, 4'hE};

  function automatic obs_t base(input logic [31:0] ir);
    obs_t o;
    o     = '0;
    o.rd  = ir[27:24];
    o.rs  = ir[23:20];
    o.rt  = ir[19:16];
    o.imm = {{16{ir[15]}}, ir[15:0]};
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.mem_req      = m.mem_req;
    o.mem_we       = m.mem_we;
    o.mem_addr_sel = m.mem_addr_sel;
    o.pc_we        = pc_we;
    o.pc_src       = pc_src;
    o.reg_we       = reg_we;
    o.reg_wsel     = reg_wsel;
    o.alu_op       = alu_op;
    o.alu_src_b    = alu_src_b;
    o.halted       = halted;
    o.illegal      = illegal;
    o.rd           = rd;
    o.rs           = rs;
    o.rt           = rt;
    o.imm          = imm_ext;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("req=%b we=%b asel=%b pcwe=%b pcsrc=%b rwe=%b rwsel=%b aop=%b srcb=%b hlt=%b ill=%b rd=%h rs=%h rt=%h imm=%h",
                     o.mem_req, o.mem_we, o.mem_addr_sel, o.pc_we, o.pc_src, o.reg_we,
                     o.reg_wsel, o.alu_op, o.alu_src_b, o.halted, o.illegal,
                     o.rd, o.rs, o.rt, o.imm);
  endfunction

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got {%s} expected {%s}", name, $time, fmt(act), fmt(exp));
  endtask

  task automatic check_reset(input string name);
    check_obs(name, sample(), '0);
    n_checks++;
    if (state_dbg === 3'd0) n_pass++;
    else $display("FAIL %s_state_dbg @%0t: got %b expected 000", name, $time, state_dbg);
  endtask

  // Monitor: one expected output vector per cycle while out of reset
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_obs("cycle", sample(), mon_e);
    end
  end

  // Memory responder: acks each request after its scheduled wait count;
  // outside requests it toggles mem_ack randomly, which must be ignored.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      wcnt = 0;
      m.mem_ack   = 1'($urandom_range(0, 1));
      m.mem_rdata = $urandom();
    end else if (m.mem_req) begin
      if (tgt_q.size() > 0 && wcnt == tgt_q[0].wait_n) begin
        m.mem_ack   = 1'b1;
        m.mem_rdata = tgt_q[0].data;
        if (tgt_q[0].is_fetch) alu_zero = tgt_q[0].zero;
        void'(tgt_q.pop_front());
        wcnt = 0;
      end else begin
        m.mem_ack   = 1'b0;
        m.mem_rdata = $urandom();
        alu_zero    = 1'($urandom_range(0, 1));
        wcnt++;
      end
    end else begin
      m.mem_ack   = 1'($urandom_range(0, 1));
      m.mem_rdata = $urandom();
    end
  end

  task automatic push_idle();
    ir_m = '0;
    exp_q.push_back(base(ir_m));
  endtask

  // Expand one instruction into its expected cycle-by-cycle outputs
  task automatic add_instr(input logic [31:0] w, input int unsigned wf,
                           input int unsigned wm, input logic z, input int unsigned hold);
    obs_t       o;
    logic [3:0] op;
    logic [2:0] aop;
    logic       is_r, ld, st, br;
    tgt_q.push_back('{wait_n: wf, data: w, is_fetch: 1'b1, zero: z});
    for (int unsigned k = 0; k <= wf; k++) begin
      o = base(ir_m); o.mem_req = 1'b1; o.pc_we = (k == wf);
      exp_q.push_back(o);
    end
    ir_m = w;
    op   = w[31:28];
    exp_q.push_back(base(ir_m));
    if (op == 4'hF || op == 4'h7 || op >= 4'hC) begin
      for (int unsigned h = 0; h < hold; h++) begin
        o = base(ir_m); o.halted = (op == 4'hF); o.illegal = (op != 4'hF);
        exp_q.push_back(o);
      end
      return;
    end
    is_r = (op <= 4'h6);
    ld   = (op == 4'h9);
    st   = (op == 4'hA);
    br   = (op == 4'hB);
    aop  = is_r ? op[2:0] : (br ? 3'b011 : 3'b010);
    o = base(ir_m); o.alu_op = aop; o.alu_src_b = !(is_r || br);
    if (br) begin o.pc_src = 1'b1; o.pc_we = z; end
    exp_q.push_back(o);
    if (ld || st) begin
      tgt_q.push_back('{wait_n: wm, data: $urandom(), is_fetch: 1'b0, zero: 1'b0});
      for (int unsigned k = 0; k <= wm; k++) begin
        o = base(ir_m); o.mem_req = 1'b1; o.mem_addr_sel = 1'b1; o.mem_we = st; o.alu_op = aop;
        exp_q.push_back(o);
      end
    end
    if (!st && !br) begin
      o = base(ir_m); o.reg_we = 1'b1; o.reg_wsel = ld; o.alu_op = aop;
      exp_q.push_back(o);
    end
  endtask

  task automatic add_random(input int unsigned n);
    logic [31:0] w;
    for (int unsigned i = 0; i < n; i++) begin
      w = $urandom();
      w[31:28] = legal_ops[$urandom_range(0, 10)];
      add_instr(w, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
    end
  endtask

  task automatic release_and_drain(input string name);
    int unsigned guard;
    @(posedge clk);
    #2 rst_n = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL %s_timeout: %0d expected cycles left, required 0", name, exp_q.size());
    end
  endtask

  task automatic do_reset(input string name);
    #2 rst_n = 1'b0;
    tgt_q.delete();
    exp_q.delete();
    #1 check_reset(name);
  endtask

  logic [31:0] tw;

  initial begin
    m.mem_ack   = 1'b0;
    m.mem_rdata = '0;
    repeat (3) @(posedge clk);
    #3 check_reset("reset");

    // Directed program from the plan, random body, ends in HALT
    push_idle();
    add_instr(32'h2123_0000, 0, 0, 1'b0, 0);
    add_instr(32'h9450_FFFC, 1, 2, 1'b0, 0);
    add_instr(32'hB012_0008, 0, 0, 1'b1, 0);
    add_instr(32'hB012_0008, 2, 0, 1'b0, 0);
    add_instr(32'hA340_0010, 0, 1, 1'b0, 0);
    add_random(30);
    add_instr(32'hF000_0000, 1, 0, 1'b0, 6);
    release_and_drain("seg_halt");
    do_reset("reset_after_halt");

    // Random program ending on illegal opcode 0xC
    push_idle();
    add_random(30);
    add_instr(32'hC123_4567, 0, 0, 1'b0, 6);
    release_and_drain("seg_illegal");
    do_reset("reset_after_illegal");

    // Random program ending on another undefined opcode
    push_idle();
    add_random(15);
    tw = $urandom();
    tw[31:28] = bad_ops[$urandom_range(0, 3)];
    add_instr(tw, 2, 0, 1'b0, 4);
    release_and_drain("seg_bad_op");
    do_reset("reset_after_bad_op");

    // SW aborted by reset in its MEM phase; the last two MEM cycles are
    // dropped so the reset lands while the store request is still pending
    push_idle();
    add_instr(32'hA340_0010, 0, 3, 1'b0, 0);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    release_and_drain("seg_sw_abort");
    do_reset("reset_mid_sw");
    @(posedge clk);
    #3 check_reset("reset_held");

    // After release: IDLE, then FETCH with IR = 0 (no ack scheduled)
    push_idle();
    for (int i = 0; i < 3; i++) begin
      mon_e = base('0);
      mon_e.mem_req = 1'b1;
      exp_q.push_back(mon_e);
    end
    release_and_drain("seg_after_abort");
    do_reset("reset_final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
